req_encoder4_2: RTL and testbench
=================================

REQ_ENCODER4_2 -- requirements
Module: req_encoder4_2

Interface
REQ-001: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-002: reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-003: enable  input  1  when 1, req SHALL be sampled; when 0, req SHALL be ignored.
REQ-004: req  input  4  request lines, one bit per requester (bit n = requester n).
REQ-005: ready  input  1  consumer accepts the offered index this cycle.
REQ-006: idx  output  2  binary index of the offered requester; SHALL be registered.
REQ-007: valid  output  1  idx holds a live offer; SHALL be registered.
REQ-008: pending  output  4  current sticky-request register.

Function
REQ-009: Grant: gnt SHALL be onehot(idx) when valid=1 and ready=1, and 0000 otherwise; ready with valid=0 SHALL have no effect.
REQ-010: Pending update, every edge: pending <= (pending & ~gnt) | (enable ? req : 0000).
REQ-011: Same-bit collision (req[n]=1 while bit n is granted, enable=1): bit n SHALL remain set and be offered again later.
REQ-012: The block SHALL have two states, IDLE (valid=0) and OFFER (valid=1).
REQ-013: Selection source sel = (pending & ~gnt) | (enable ? req : 0000), which equals next-cycle pending.
REQ-014: In IDLE, or in OFFER with ready=1: valid <= |sel and idx <= select(sel); the state becomes OFFER if sel != 0000, otherwise IDLE.
REQ-015: In OFFER with ready=0: idx and valid SHALL hold, even if a higher-priority request arrives.
REQ-016: Latency: req high with enable=1 before edge N in IDLE SHALL give valid=1 and the correct idx immediately after edge N (one cycle).
REQ-017: Back-to-back throughput: with ready held at 1, one grant SHALL be issued per cycle while sel is non-zero.
REQ-018: In IDLE, idx SHALL retain its last value and SHALL NOT be interpreted.
REQ-019: When the offered bit is the only pending bit and it is granted, valid SHALL fall after that edge unless new requests arrive.

Reset
REQ-020: Asserting reset low SHALL immediately force pending=0000, valid=0, idx=00, rr pointer=11, and state IDLE, independent of clk.
REQ-021: Reset asserted during OFFER SHALL discard the offer and all pending bits; no grant SHALL be counted.
REQ-022: After reset deasserts, the first sampling edge SHALL follow normal REQ-014 behaviour.

Configuration
REQ-023: Macro REQ_ENCODER_ROUND_ROBIN_EN selects the arbitration policy used by select().
REQ-024: Macro defined (round robin):
- a 2-bit pointer ptr is updated to idx on each grant.
- select() SHALL search bits ptr+1, ptr+2, ptr+3, ptr (mod 4) and return the first set bit.
REQ-025: Macro undefined (fixed priority):
- select() SHALL return the highest set index (3 > 2 > 1 > 0).
- no pointer state SHALL exist.
REQ-026: Interface, latency and reset behaviour SHALL be identical under both settings.

Verification
REQ-027: Reset: assert reset low mid-OFFER with pending=1010 -> valid=0, pending=0000, idx=00 immediately, without waiting for a clock edge.
REQ-028: Single request: enable=1, req=0100 for one cycle, ready=1 -> valid=1 and idx=10 after one edge, then valid=0 on the next edge.
REQ-029: Backpressure: pending=0001 offered (idx=00), ready=0, req=1000 arrives -> idx stays 00 and pending=1001; on ready=1, idx=11 on the following cycle.
REQ-030: All four requests: req=1111 for one cycle, ready=1 held -> fixed priority gives idx sequence 11,10,01,00 then valid=0; round robin from reset gives 00,01,10,11.
REQ-031: Collision: offer idx=01, ready=1, req=0010 on the same cycle -> bit 1 stays pending; fixed priority re-offers idx=01 next cycle.
REQ-032: enable=0 with req=1111 and pending=0000 -> no change to pending, valid stays 0.

Source files
------------

// File: rtl/req_encoder4_2.sv
// req_encoder4_2: sticky 4-input request encoder with a registered ready/valid index offer.
// Define REQ_ENCODER_ROUND_ROBIN_EN for round-robin selection; otherwise highest index wins.
module req_encoder4_2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [3:0] i_req,
    input  logic       i_ready,
    output logic [1:0] o_idx,
    output logic       o_valid,
    output logic [3:0] o_pending
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t     r_state, w_state_nxt;
    logic [3:0] r_pending, w_gnt, w_sel;
    logic [1:0] r_idx, w_idx_nxt, w_pick;
    logic       w_grant, w_reload;

    assign w_grant  = (r_state == OFFER) && i_ready;
    assign w_gnt    = w_grant ? 4'b0001 << r_idx : 4'b0000;
    assign w_sel    = (r_pending & ~w_gnt) | (i_enable ? i_req : 4'b0000);
    assign w_reload = (r_state == IDLE) || i_ready;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    logic [1:0] r_ptr, w_base;
    logic [7:0] w_dbl;
    logic [3:0] w_rot;
    // The pointer moves to the granted index this same edge, so search from it directly.
    assign w_base = w_grant ? r_idx : r_ptr;
    always_comb begin
        w_dbl  = {w_sel, w_sel} >> ({1'b0, w_base} + 3'd1);
        w_rot  = w_dbl[3:0];
        w_pick = w_rot[0] ? w_base + 2'd1 :
                 w_rot[1] ? w_base + 2'd2 :
                 w_rot[2] ? w_base + 2'd3 : w_base;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_ptr <= 2'b11;
        else if (w_grant)
            r_ptr <= r_idx;
    end
`else
    assign w_pick = w_sel[3] ? 2'd3 : w_sel[2] ? 2'd2 : w_sel[1] ? 2'd1 : 2'd0;
`endif

    // Under backpressure the current offer is frozen; only pending keeps accumulating.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (w_reload) begin
            w_state_nxt = |w_sel ? OFFER : IDLE;
            w_idx_nxt   = |w_sel ? w_pick : r_idx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_pending <= 4'b0000;
            r_idx     <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_sel;
            r_idx     <= w_idx_nxt;
        end
    end

    assign o_idx     = r_idx;
    assign o_valid   = r_state == OFFER;
    assign o_pending = r_pending;
endmodule

// File: tb/tb_req_encoder4_2.sv
// tb_req_encoder4_2: scoreboard bench; a cycle model pushes expected outputs, popped after each edge.
module tb_req_encoder4_2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       ready = 1'b0;
    logic [1:0] idx;
    logic       valid;
    logic [3:0] pending;

    int checks = 0;
    int failures = 0;
    logic [6:0] sb_q[$];

    logic [3:0] m_pending = 4'b0000;
    logic [1:0] m_idx = 2'b00;
    logic [1:0] m_ptr = 2'b11;
    logic       m_valid = 1'b0;

    req_encoder4_2 dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_req(req),
        .i_ready(ready), .o_idx(idx), .o_valid(valid), .o_pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] pick(input logic [3:0] s, input logic [1:0] base);
        logic [1:0] r;
        r = 2'b00;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
        for (int k = 4; k >= 1; k--)
            if (s[(int'(base) + k) % 4]) r = 2'((int'(base) + k) % 4);
`else
        for (int i = 0; i < 4; i++)
            if (s[i]) r = 2'(i);
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_pending = 4'b0000;
        m_idx = 2'b00;
        m_ptr = 2'b11;
        m_valid = 1'b0;
    endtask

    task automatic drive(input logic en, input logic [3:0] rq, input logic rdy, input string tag);
        logic [3:0] gnt, sel;
        logic [6:0] e;
        @(negedge clk);
        enable = en;
        req = rq;
        ready = rdy;
        gnt = 4'b0000;
        if (m_valid && rdy) gnt[m_idx] = 1'b1;
        sel = (m_pending & ~gnt) | (en ? rq : 4'b0000);
        if (!m_valid || rdy) begin
            if (sel != 4'b0000) m_idx = pick(sel, (gnt != 4'b0000) ? m_idx : m_ptr);
            m_valid = sel != 4'b0000;
        end
        if (gnt != 4'b0000)
            for (int i = 0; i < 4; i++) if (gnt[i]) m_ptr = 2'(i);
        m_pending = sel;
        sb_q.push_back({m_idx, m_valid, m_pending});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".valid"}, {3'b000, valid}, {3'b000, e[4]});
        chk({tag, ".pending"}, pending, e[3:0]);
        chk({tag, ".idx"}, {2'b00, idx}, {2'b00, e[6:5]});
    endtask

    initial begin
        #2;
        chk("rst.valid", {3'b000, valid}, 4'b0000);
        chk("rst.pending", pending, 4'b0000);
        chk("rst.idx", {2'b00, idx}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'b1111, 1'b0, "en0a");
        drive(1'b0, 4'b1111, 1'b1, "en0b");
        drive(1'b1, 4'b0100, 1'b1, "single0");
        chk("single.idx_abs", {2'b00, idx}, 4'b0010);
        drive(1'b0, 4'b0000, 1'b1, "single1");
        chk("single.drop", {3'b000, valid}, 4'b0000);
        drive(1'b0, 4'b0000, 1'b1, "single2");
        drive(1'b1, 4'b0001, 1'b0, "bp0");
        drive(1'b1, 4'b1000, 1'b0, "bp1");
        chk("bp.pend_abs", pending, 4'b1001);
        drive(1'b0, 4'b0000, 1'b1, "bp2");
        chk("bp.idx_abs", {2'b00, idx}, 4'b0011);
        drive(1'b0, 4'b0000, 1'b1, "bp3");
        drive(1'b1, 4'b1111, 1'b1, "all0");
        for (int i = 1; i <= 5; i++) drive(1'b0, 4'b0000, 1'b1, $sformatf("all%0d", i));
        drive(1'b1, 4'b0010, 1'b1, "col0");
        drive(1'b1, 4'b0010, 1'b1, "col1");
        drive(1'b0, 4'b0000, 1'b1, "col2");
        drive(1'b0, 4'b0000, 1'b1, "col3");
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  $sformatf("rnd%0d", i));
        drive(1'b0, 4'b0000, 1'b1, "flush0");
        for (int i = 1; i <= 4; i++) drive(1'b0, 4'b0000, 1'b1, $sformatf("flush%0d", i));
        drive(1'b1, 4'b1010, 1'b0, "pre_rst");
        chk("pre_rst.pend_abs", pending, 4'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.valid", {3'b000, valid}, 4'b0000);
        chk("arst.pending", pending, 4'b0000);
        chk("arst.idx", {2'b00, idx}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'b0110, 1'b1, "post0");
        drive(1'b0, 4'b0000, 1'b1, "post1");
        drive(1'b0, 4'b0000, 1'b1, "post2");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
